// File: rtl/alu_seq_ctrl.sv
// Bit-serial sequencer driving an external 1-bit four-function ALU, LSB first; optional parity output under ALU_SEQ_PARITY_EN.
// Latency: accept at edge T, result valid from edge T+WIDTH; one operation per WIDTH+2 cycles with out_ready held high.
// Backpressure: result held in DONE until out_ready; in_ready low outside IDLE, requests are not queued.
module alu_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             alu_s0,
    output logic             alu_s1,
    output logic             alu_d0,
    output logic             alu_d1,
    input  logic             alu_o
`ifdef ALU_SEQ_PARITY_EN
    ,
    output logic             out_parity
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Index of the last bit; RUN ends on the edge that processes it.
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       op_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] res_reg;
    logic [CNT_W-1:0] idx;
    logic             accept;
    logic             last_bit;

    assign accept   = in_valid && in_ready;
    assign last_bit = (idx == LAST_IDX);

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and state-decoded outputs; ALU pins parked at AND/zero outside RUN.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        alu_s0    = 1'b0;
        alu_s1    = 1'b0;
        alu_d0    = 1'b0;
        alu_d1    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                alu_s0 = op_reg[1];
                alu_s1 = op_reg[0];
                alu_d0 = a_reg[idx];
                alu_d1 = b_reg[idx];
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand capture on accept, then one result bit collected per RUN cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_reg  <= 2'b00;
            a_reg   <= '0;
            b_reg   <= '0;
            res_reg <= '0;
            idx     <= '0;
        end else begin
            if (state == IDLE && accept) begin
                op_reg  <= in_op;
                a_reg   <= in_a;
                b_reg   <= in_b;
                res_reg <= '0;
                idx     <= '0;
            end else if (state == RUN) begin
                res_reg[idx] <= alu_o;
                idx          <= last_bit ? '0 : idx + 1'b1;
            end
        end
    end

    assign out_result = res_reg;

`ifdef ALU_SEQ_PARITY_EN
    logic parity_reg;

    // Running XOR of the result bits as they arrive from the ALU.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            parity_reg <= 1'b0;
        end else if (state == IDLE && accept) begin
            parity_reg <= 1'b0;
        end else if (state == RUN) begin
            parity_reg <= parity_reg ^ alu_o;
        end
    end

    assign out_parity = parity_reg;
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl at WIDTH=8 and WIDTH=1, each with a behavioural ALU model.
// Inputs driven and outputs sampled on the falling clock edge.
// Random operations with random result backpressure, plus directed reset and bit-order cases.
module tb_alu_seq_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    always #5 clk = ~clk;

    // WIDTH=8 instance signals
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [1:0]   in_op;
    logic [W-1:0] in_a, in_b, out_result;
    logic         alu_s0, alu_s1, alu_d0, alu_d1, alu_o;
`ifdef ALU_SEQ_PARITY_EN
    logic         out_parity;
`endif

    // WIDTH=1 instance signals
    logic         in_valid1, in_ready1, out_valid1, out_ready1;
    logic [1:0]   in_op1;
    logic [0:0]   in_a1, in_b1, out_result1;
    logic         alu_s0_1, alu_s1_1, alu_d0_1, alu_d1_1, alu_o_1;
`ifdef ALU_SEQ_PARITY_EN
    logic         out_parity1;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    alu_seq_ctrl #(.WIDTH(W)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .alu_s0(alu_s0), .alu_s1(alu_s1), .alu_d0(alu_d0), .alu_d1(alu_d1), .alu_o(alu_o)
`ifdef ALU_SEQ_PARITY_EN
        , .out_parity(out_parity)
`endif
    );

    alu_seq_ctrl #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_op(in_op1), .in_a(in_a1), .in_b(in_b1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_result(out_result1),
        .alu_s0(alu_s0_1), .alu_s1(alu_s1_1), .alu_d0(alu_d0_1), .alu_d1(alu_d1_1), .alu_o(alu_o_1)
`ifdef ALU_SEQ_PARITY_EN
        , .out_parity(out_parity1)
`endif
    );

    // External 1-bit ALU: S0S1 = 00 AND, 01 OR, 10 XOR, 11 NOT D0.
    function automatic logic alu_bit(input logic s0, input logic s1, input logic d0, input logic d1);
        case ({s0, s1})
            2'b00:   return d0 & d1;
            2'b01:   return d0 | d1;
            2'b10:   return d0 ^ d1;
            default: return ~d0;
        endcase
    endfunction

    assign alu_o   = alu_bit(alu_s0, alu_s1, alu_d0, alu_d1);
    assign alu_o_1 = alu_bit(alu_s0_1, alu_s1_1, alu_d0_1, alu_d1_1);

    // Word-level reference for the requested operation.
    function automatic logic [W-1:0] ref_res(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~a;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One full transaction on the WIDTH=8 instance; starts and ends on a falling edge.
    task automatic do_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
        logic [W-1:0] exp;
        int waited;
        exp    = ref_res(op, a, b);
        waited = 0;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("in_ready_before_accept", in_ready, 1);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        @(negedge clk);
        in_valid = 1'b0;
        in_op    = 2'($urandom);
        in_a     = W'($urandom);
        in_b     = W'($urandom);
        for (int k = 0; k < W; k++) begin
            if (k > 0) @(negedge clk);
            chk("run_out_valid", out_valid, 0);
            chk("run_in_ready", in_ready, 0);
            chk("run_alu_s0", alu_s0, op[1]);
            chk("run_alu_s1", alu_s1, op[0]);
            chk("run_alu_d0", alu_d0, a[k]);
            chk("run_alu_d1", alu_d1, b[k]);
            out_ready = 1'($urandom);
            in_valid  = 1'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("done_out_valid", out_valid, 1);
        chk("done_result", out_result, exp);
        chk("done_in_ready", in_ready, 0);
        chk("done_alu_idle", {alu_s0, alu_s1, alu_d0, alu_d1}, 0);
`ifdef ALU_SEQ_PARITY_EN
        chk("done_parity", out_parity, ^exp);
`endif
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            in_valid  = 1'($urandom);
            in_a      = W'($urandom);
            @(negedge clk);
            chk("hold_out_valid", out_valid, 1);
            chk("hold_result", out_result, exp);
            chk("hold_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("post_hs_out_valid", out_valid, 0);
        chk("post_hs_in_ready", in_ready, 1);
        out_ready = 1'b0;
    endtask

    // One transaction on the WIDTH=1 instance.
    task automatic do_op1(input logic [1:0] op, input logic a, input logic b);
        logic [W-1:0] full;
        logic         exp;
        full = ref_res(op, {7'b0, a}, {7'b0, b});
        exp  = full[0];
        chk("w1_in_ready", in_ready1, 1);
        in_valid1 = 1'b1;
        in_op1    = op;
        in_a1     = a;
        in_b1     = b;
        @(negedge clk);
        in_valid1 = 1'b0;
        in_a1     = ~a;
        chk("w1_run_out_valid", out_valid1, 0);
        chk("w1_run_sel", {alu_s0_1, alu_s1_1}, op);
        chk("w1_run_d0", alu_d0_1, a);
        @(negedge clk);
        chk("w1_done_out_valid", out_valid1, 1);
        chk("w1_done_result", out_result1, exp);
`ifdef ALU_SEQ_PARITY_EN
        chk("w1_done_parity", out_parity1, exp);
`endif
        out_ready1 = 1'b1;
        @(negedge clk);
        chk("w1_post_hs_out_valid", out_valid1, 0);
        out_ready1 = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen_valid;
        rst_n      = 1'b0;
        in_valid   = 1'b0; in_op  = 2'b00; in_a  = '0; in_b  = '0; out_ready  = 1'b0;
        in_valid1  = 1'b0; in_op1 = 2'b00; in_a1 = '0; in_b1 = '0; out_ready1 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_alu_outputs", {alu_s0, alu_s1, alu_d0, alu_d1}, 0);
        chk("rst_w1_in_ready", in_ready1, 1);

        // Canonical operand pair through all four operations, back to back.
        for (int op = 0; op < 4; op++) do_op(2'(op), 8'hC5, 8'h3C, 0);

        // Bit ordering: only bit 0 of A set.
        do_op(2'b10, 8'h01, 8'h00, 0);

        // Backpressure for five cycles.
        do_op(2'b01, 8'h5A, 8'h81, 5);

        // Reset while RUN is at idx=3.
        in_valid = 1'b1; in_op = 2'b10; in_a = 8'hA5; in_b = 8'h3C;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_alu_d0_idx3", alu_d0, 0);
        chk("midrst_alu_d1_idx3", alu_d1, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_result", out_result, 0);
        chk("midrst_alu_outputs", {alu_s0, alu_s1, alu_d0, alu_d1}, 0);
        seen_valid = 1'b0;
        repeat (W + 3) begin
            @(negedge clk);
            if (out_valid) seen_valid = 1'b1;
        end
        chk("midrst_no_out_valid", seen_valid, 0);
        do_op(2'b00, 8'hFF, 8'h0F, 0);

        // Randomized operations with random backpressure.
        for (int i = 0; i < 30; i++) begin
            do_op(2'($urandom), W'($urandom), W'($urandom), int'($urandom_range(0, 4)));
        end

        // WIDTH=1 instance.
        do_op1(2'b11, 1'b0, 1'b0);
        do_op1(2'b00, 1'b1, 1'b1);
        do_op1(2'b10, 1'b1, 1'b1);
        do_op1(2'b01, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Bit-serial sequencer for the team's 1-bit four-function ALU (select S0/S1, data D0/D1, result O0).
- Accepts one WIDTH-bit bitwise operation through a valid/ready handshake and drives the ALU one bit per clock, LSB first.
- Collects the ALU output bits and returns the WIDTH-bit result through a valid/ready handshake.
- Sits between the requester and one external combinational ALU instance. The ALU itself is not instantiated inside this block.

Parameters:
- WIDTH, 8, operand/result width in bits (legal range 1..32).
- CNT_W, $clog2(WIDTH) (minimum 1), width of the bit-index counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active-low
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request
- in_op  in  2  operation: 00 AND, 01 OR, 10 XOR, 11 NOT A
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B (ignored for op 11)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_result  out  WIDTH  result word
- alu_s0  out  1  to ALU S0 (= op[1])
- alu_s1  out  1  to ALU S1 (= op[0])
- alu_d0  out  1  to ALU D0 (bit of A)
- alu_d1  out  1  to ALU D1 (bit of B)
- alu_o  in  1  from ALU O0, combinational on alu_* outputs

Behaviour:
- One clock domain (clk). Reset is synchronous and active-low: rst_n is sampled on the clk rising edge.
- Reset values: state=IDLE, idx=0, in_ready=1, out_valid=0, out_result=0, alu_s0=alu_s1=alu_d0=alu_d1=0, op/A/B registers=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at an edge: latch in_op, in_a, in_b; clear the result register; idx<=0; go to RUN.
- RUN:
  - in_ready=0.
  - alu_s0/alu_s1 driven from the latched op. alu_d0=a_reg[idx], alu_d1=b_reg[idx].
  - Each edge: res_reg[idx]<=alu_o; idx<=idx+1.
  - On the edge where idx==WIDTH-1: go to DONE and set idx<=0. The counter never wraps past WIDTH-1.
- DONE:
  - out_valid=1; out_result=res_reg, held stable until the handshake.
  - On out_valid&out_ready: go to IDLE, out_valid<=0.
  - in_ready=0 throughout DONE. A new request is accepted no earlier than the cycle after the result handshake; there is no overlap.
- Latency: accept edge at T; RUN occupies the WIDTH cycles after T; out_valid is high starting at edge T+WIDTH.
- Throughput: one operation per WIDTH+2 cycles when out_ready is held high.
- WIDTH=1: RUN lasts exactly one cycle.
- Outside RUN, the alu_* outputs are driven to 0 (AND select, zero data). The ALU output is ignored outside RUN.
- Input operands may change freely after acceptance; only the latched copies are used.
- out_ready is ignored while out_valid=0. in_valid while in_ready=0 is ignored; the request is not queued.
- Reset asserted in any state (including mid-RUN or DONE with a pending result): next edge returns to IDLE with all reset values. The partial result is discarded and no out_valid pulse is produced.
- in_ready is a function of state only, with no combinational path from out_ready.

Optional Feature:
- Macro ALU_SEQ_PARITY_EN.
- Defined:
  - Adds output out_parity (1 bit) = XOR of all result bits.
  - Accumulated serially: parity_reg <= parity_reg ^ alu_o on each RUN edge; cleared on accept and on reset.
  - Valid whenever out_valid=1.
- Not defined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset: hold rst_n=0 for 2 edges, release -> in_ready=1, out_valid=0, out_result=0x00, all alu_* outputs 0.
- WIDTH=8, A=0xC5, B=0x3C, ops 00/01/10/11 in sequence, out_ready=1 -> results 0x04, 0xFD, 0xF9, 0x3A; out_valid exactly 8 edges after each accept; with ALU_SEQ_PARITY_EN, out_parity 1, 1, 0, 0.
- Bit ordering: op 10, A=0x01, B=0x00 -> alu_d0=1 only in the first RUN cycle (idx=0); result 0x01.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> out_valid and out_result held; in_ready=0; in_valid pulses ignored; on out_ready=1, IDLE the next cycle and the next request is accepted.
- Reset mid-operation: rst_n=0 at RUN idx=3 -> IDLE next edge, out_valid never asserts; a following request A=0xFF, B=0x0F, op 00 -> 0x0F.
- WIDTH=1 build: op 11, A=0 -> result 1 one edge after accept.
